button_conditioner: RTL
=======================

# button_conditioner

Conditions the five raw, active-low push-button inputs before they reach the whack-a-mole game core. It synchronizes each button into the `clk` domain, debounces it with a per-channel stability counter, and emits a clean active-high level plus single-cycle press and release pulses. The game core consumes `btn_press` directly, so it no longer needs its own edge-detect registers.

## Interface
Parameters:
- `N_BTN`, 5, number of button channels.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles needed to accept a change (10 ms at 100 MHz). Must be ≥ 2.
- `CNT_W`, $clog2(DEBOUNCE_CYCLES), counter width. Derived; never overridden.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_raw_n`  in  N_BTN  raw button pins; 0 = pressed; asynchronous to `clk`.
- `btn_level`  out  N_BTN  debounced state; 1 = pressed.
- `btn_press`  out  N_BTN  one-cycle pulse on each accepted press (0→1 of `btn_level`).
- `btn_release`  out  N_BTN  one-cycle pulse on each accepted release (1→0 of `btn_level`).
- `any_press`  out  1  OR of `btn_press`; same cycle as the pulses.

## Operation
Each channel is independent and identical.

- **Synchronizer:**
  - 2-flop chain on the inverted raw pin.
  - `sync = ~btn_raw_n` after two flops.
  - Both flops reset to 0 (released).
- **Per-channel state:** `stable` (drives `btn_level`) and `cnt[CNT_W-1:0]`.
- **Each clock edge:**
  - If `sync == stable`: `cnt <= 0`. No pulse.
  - If `sync != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - If `sync != stable` and `cnt == DEBOUNCE_CYCLES-1`:
    - `stable <= sync`, `cnt <= 0`.
    - Pulse `btn_press` (if `sync` = 1) or `btn_release` (if `sync` = 0) for exactly that one cycle.
- Any return of `sync` to `stable` before the terminal count clears `cnt`. A glitch shorter than DEBOUNCE_CYCLES never changes `btn_level`.
- `cnt` never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
- Simultaneous changes on several channels each produce their own pulse. Pulses on different channels may coincide in the same cycle.
- `btn_press` and `btn_release` are never both high on one channel in the same cycle.
- **Reset values:** all outputs 0, all `cnt` 0, all sync flops 0. Reset asserted mid-count discards progress immediately.
- **After reset release:** a button already held goes through a full debounce and yields one `btn_press`.

## Timing
- All outputs are registered; no combinational path from `btn_raw_n`.
- `any_press` is registered in parallel with `btn_press`, not ORed after the flops.
- **Latency:** a raw change held stable appears on `btn_level` and the matching pulse DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it. This is 2 sync cycles plus DEBOUNCE_CYCLES.
- **Pulse width:** exactly 1 cycle. Minimum spacing between pulses on one channel is DEBOUNCE_CYCLES cycles.
- Reset deassertion is assumed synchronized externally to `clk`. Asynchronous assertion takes effect without a clock.

## Structure
- **Shared package `game_pkg`:**
  - `N_BTN` = 5
  - `DEBOUNCE_10MS` = 1_000_000
  - `DEBOUNCE_SIM` = 4, for benches
- **Sub-module `debounce_channel`:** one synchronizer + counter + stable flag + pulse flops. Instantiated N_BTN times with a generate loop.
- The top level adds only the `any_press` register.

## Test plan
DEBOUNCE_CYCLES = 4 throughout.

1. **Reset:** assert `reset`=0 with `btn_raw_n`=5'b11111, then release. → All outputs 0. No pulse for 20 cycles.
2. **Clean press:** drive `btn_raw_n[0]`=0 and hold.
   - `btn_level[0]` rises and `btn_press[0]`=1 for exactly 1 cycle, 6 edges after the first sampling edge.
   - `any_press`=1 in the same cycle.
   - Releasing later gives `btn_release[0]` 6 edges after release.
3. **Glitch rejection:** pulse `btn_raw_n[2]` low for 3 cycles, then high. → `btn_level[2]` stays 0. No pulses.
4. **Bounce:** toggle `btn_raw_n[3]` low/high every 2 cycles for 10 cycles, then hold low. → Exactly one `btn_press[3]`, 6 edges after the final low begins.
5. **Simultaneous:** drive `btn_raw_n`=5'b00000 on one edge. → `btn_press`=5'b11111 for one cycle and `any_press`=1, both 6 edges later.
6. **Reset mid-count:** hold `btn_raw_n[1]`=0; assert `reset` after 3 cycles, release 2 cycles later, keep the button low.
   - Outputs clear immediately on reset.
   - After release, `btn_press[1]` arrives 6 edges later.
   - Exactly one pulse in total.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for the whack-a-mole game: button count and debounce windows.
package game_pkg;

    localparam int unsigned N_BTN         = 5;
    localparam int unsigned DEBOUNCE_10MS = 1_000_000;
    localparam int unsigned DEBOUNCE_SIM  = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level
// and single-cycle press/release pulses.
module debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_raw_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_press_next_c
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;

    logic w_differ;
    logic w_accept;
    logic w_press_next;
    logic w_release_next;

    // A change is accepted on the edge where the counter already sits at terminal.
    assign w_differ       = r_sync2 != r_stable;
    assign w_accept       = w_differ && (r_cnt == CNT_TERM);
    assign w_press_next   = w_accept && r_sync2;
    assign w_release_next = w_accept && !r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_stable  <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= ~i_btn_raw_n;
            r_sync2   <= r_sync1;
            r_press   <= w_press_next;
            r_release <= w_release_next;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level        = r_stable;
    assign o_press        = r_press;
    assign o_release      = r_release;
    assign o_press_next_c = w_press_next;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw active-low game buttons into debounced levels and
// single-cycle press/release pulses, plus a registered any-press flag.
module button_conditioner #(
    parameter int unsigned N_BTN           = game_pkg::N_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_10MS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [N_BTN-1:0] w_press_next;
    logic             r_any_press;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .i_btn_raw_n    (btn_raw_n[g]),
            .o_level        (btn_level[g]),
            .o_press        (btn_press[g]),
            .o_release      (btn_release[g]),
            .o_press_next_c (w_press_next[g])
        );
    end

    // Registered from the channels' next-press terms so it lines up with btn_press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_next;
        end
    end

    assign any_press = r_any_press;

endmodule
